serial_adder_sub: RTL and testbench
===================================

// Module: serial_adder_sub
//
// PURPOSE
// - Multi-cycle adder/subtractor. A single BITS_PER_CYCLE-wide full-adder slice processes
//   WIDTH-bit operands LSB-first, over WIDTH/BITS_PER_CYCLE cycles.
// - A registered carry links successive slices.
// - Parametrised, clocked successor to the lab full-adder cell: trades latency for area.
// - Control is a start/busy/done handshake, used by datapath sequencers in later labs.
//
// PARAMETERS
// - WIDTH           8  operand/result width in bits; >= 2
// - BITS_PER_CYCLE  1  bits summed per cycle; must divide WIDTH (elaboration $error otherwise)
//
// PORTS
// - clk       in   1      rising-edge clock
// - rst_n     in   1      synchronous reset, active-low
// - start     in   1      request; sampled only when busy=0
// - sub       in   1      0: a+b+cin; 1: a-b (b inverted, carry-in forced 1, cin ignored)
// - cin       in   1      carry-in for add mode
// - a         in   WIDTH  operand A, captured on accepted start
// - b         in   WIDTH  operand B, captured on accepted start
// - busy      out  1      high while the operation is in progress
// - done      out  1      one-cycle pulse: result valid
// - sum       out  WIDTH  result; held until the next accepted start
// - cout      out  1      carry out of MSB; in sub mode 1 = no borrow
// - overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
// - STEPS = WIDTH/BITS_PER_CYCLE.
// - FSM states: IDLE, RUN, DONE.
// - Reset (rst_n=0 at a clk edge):
//   - state returns to IDLE.
//   - busy, done, sum, cout and overflow all go to 0.
//   - The internal shift registers, carry and step counter are cleared.
//   - Reset takes priority over all other inputs, including mid-RUN.
// - IDLE or DONE, start=1 at edge k:
//   - capture a and (sub ? ~b : b) into shift registers.
//   - carry <= sub ? 1 : cin; counter <= 0; go to RUN.
//   - busy=1 from edge k until the operation completes.
// - RUN, each edge:
//   - add the low BITS_PER_CYCLE bits of both registers plus carry.
//   - shift the slice sum into the top of the result register (LSB-first fill).
//   - shift the operand registers right by BITS_PER_CYCLE; update carry; counter++.
//   - Before the MSB slice, record the carry into bit WIDTH-1 for overflow.
// - RUN, last step (counter = STEPS-1) at edge k+STEPS:
//   - sum, cout and overflow are registered.
//   - done=1 and busy=0; state goes to DONE.
// - Latency: start sampled at edge k, results valid and done=1 after edge k+STEPS.
// - DONE lasts one cycle:
//   - done returns to 0 at the next edge.
//   - The next state is RUN if start=1 at that edge, otherwise IDLE.
//   - Back-to-back issue gives throughput of one operation per STEPS+1 cycles.
// - start while busy=1 is ignored. Operands and mode stay as captured; a, b, sub and cin
//   may change freely during RUN.
// - sum, cout and overflow change only at the final RUN edge or on reset. They are never
//   visible partially updated.
// - Arithmetic is modulo 2^WIDTH. {cout,sum} equals a + (sub ? ~b+1 : b+cin) as a
//   (WIDTH+1)-bit value.
// - Counter width is $clog2(STEPS)+1, so STEPS=1 is legal and takes one RUN cycle.
//
// TESTING (WIDTH=8, BITS_PER_CYCLE=1 unless noted; start pulse at edge k)
// - add 0x5A + 0x33, cin=0 -> sum=0x8D, cout=0, overflow=1.
//   - done high only after edge k+8; busy high for edges k..k+7.
// - add 0xFF + 0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
//   - Also 0x00 + 0x00 with cin=1 -> sum=0x01.
// - sub 0x10 - 0x20 -> sum=0xF0, cout=0, overflow=0.
//   - sub 0x80 - 0x01 -> sum=0x7F, cout=1, overflow=1.
// - Assert start with new operands at edges k+3 and k+5 of a running op:
//   - both requests are ignored; the original result is returned unchanged.
// - Back-to-back: start held high through DONE:
//   - the second op begins at the DONE edge; its done comes exactly 9 cycles after the first.
// - rst_n=0 at edge k+4 mid-RUN:
//   - all outputs are 0 and state is IDLE after that edge.
//   - A fresh op started after release gives the correct result.
// - WIDTH=4, BITS_PER_CYCLE=2 (and BITS_PER_CYCLE=4):
//   - exhaustive a, b, cin, sub checked against a behavioural reference model.
//   - Latency is 2 (and 1) cycles respectively.

Source files
------------

// File: rtl/serial_adder_sub.sv
// serial_adder_sub
// Multi-cycle adder/subtractor. One BITS_PER_CYCLE-wide full-adder slice walks
// the WIDTH-bit operands LSB-first. A registered carry links successive slices.
// A start/busy/done handshake frames each operation. The result, carry-out and
// signed overflow are published together on the final slice edge and are never
// seen partially updated.

module serial_adder_sub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    // One spare bit keeps the counter legal when STEPS = 1.
    localparam int CNT_W = $clog2(STEPS) + 1;

    if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_check
        $error("serial_adder_sub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ripple a B-bit slice.
    // The result is packed as {carry into top bit, carry out, slice sum}.
    // The carry into the top bit of the slice is only meaningful on the MSB
    // slice, where it becomes the carry into bit WIDTH-1 for overflow.
    function automatic logic [B+1:0] slice_add(
        input logic [B-1:0] x,
        input logic [B-1:0] y,
        input logic         c_in
    );
        logic [B-1:0] s;
        logic         c;
        logic         c_top;
        s     = '0;
        c     = c_in;
        c_top = c_in;
        for (int i = 0; i < B; i++) begin
            if (i == B - 1) begin
                c_top = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c_top, c, s};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [B+1:0]       slice_res;
    logic [B-1:0]       slice_sum;
    logic               slice_cout;
    logic               slice_ctop;
    logic [WIDTH-1:0]   acc_shift;
    logic               last_step;

    // Slice arithmetic on the low bits of the operand shift registers.
    always_comb begin
        slice_res  = slice_add(opa_q[B-1:0], opb_q[B-1:0], carry_q);
        slice_sum  = slice_res[B-1:0];
        slice_cout = slice_res[B];
        slice_ctop = slice_res[B+1];
        // The result register fills from the top, so after STEPS shifts the
        // first slice has reached bit 0.
        acc_shift                = acc_q >> B;
        acc_shift[WIDTH-1 -: B]  = slice_sum;
        last_step                = (cnt_q == CNT_W'(STEPS - 1));
    end

    // Next-state logic and handshake outputs for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b once on capture and
                    // force the first carry in, so the slice only ever adds.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                opa_d   = opa_q >> B;
                opb_d   = opb_q >> B;
                acc_d   = acc_shift;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (last_step) begin
                    // All visible results update together on this edge only.
                    sum_d   = acc_shift;
                    cout_d  = slice_cout;
                    ovf_d   = slice_ctop ^ slice_cout;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Testbench for serial_adder_sub: directed 8-bit vectors with hand-computed
// results, handshake timing, ignored starts, back-to-back issue and mid-run
// reset, plus exhaustive 4-bit runs at 2 and 4 bits per cycle.

module tb_serial_adder_sub;

    logic       clk;
    logic       rst_n;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic       busyA, doneA, coutA, ovfA;
    logic [3:0] sumA;
    logic       busyB, doneB, coutB, ovfB;
    logic [3:0] sumB;

    int errors;
    int checks;

    serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .overflow(ovf8)
    );

    serial_adder_sub #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4x2 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
        .a(a4), .b(b4), .busy(busyA), .done(doneA), .sum(sumA),
        .cout(coutA), .overflow(ovfA)
    );

    serial_adder_sub #(.WIDTH(4), .BITS_PER_CYCLE(4)) dut4x4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
        .a(a4), .b(b4), .busy(busyB), .done(doneB), .sum(sumB),
        .cout(coutB), .overflow(ovfB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_w8: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        checks++;
        if ({busyA, doneA, sumA, coutA, ovfA} !== 8'h00) begin
            errors++;
            $display("FAIL reset_w4b2: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busyA, doneA, sumA, coutA, ovfA);
        end
        checks++;
        if ({busyB, doneB, sumB, coutB, ovfB} !== 8'h00) begin
            errors++;
            $display("FAIL reset_w4b4: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busyB, doneB, sumB, coutB, ovfB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy8, done8);
        end
    endtask

    // One 8-bit operation with full handshake timing checks.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input logic tc,
                       input logic [7:0] es, input logic ec, input logic eo, input string nm);
        @(negedge clk);
        a8 = ta; b8 = tb; sub8 = ts; cin8 = tc; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        // Inputs may wander during RUN without affecting the result.
        a8 = ~ta; b8 = ~tb; sub8 = ~ts; cin8 = ~tc;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: busy=%b done=%b, want 1 0", nm, busy8, done8);
        end
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy8 !== (i < 8) || done8 !== (i == 8)) begin
                errors++;
                $display("FAIL %s_hs_cycle%0d: busy=%b done=%b, want %b %b",
                         nm, i, busy8, done8, (i < 8), (i == 8));
            end
        end
        checks++;
        if (sum8 !== es || cout8 !== ec || ovf8 !== eo) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     nm, sum8, cout8, ovf8, es, ec, eo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== es) begin
            errors++;
            $display("FAIL %s_after: busy=%b done=%b sum=%h, want 0 0 %h", nm, busy8, done8, sum8, es);
        end
    endtask

    task automatic test_add_sub();
        op8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        op8(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, "add_cin");
        op8(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        op8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start8 = (i == 3 || i == 5);
            a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b1; cin8 = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (busy8 !== (i < 8) || done8 !== (i == 8)) begin
                errors++;
                $display("FAIL ignore_hs_cycle%0d: busy=%b done=%b, want %b %b",
                         i, busy8, done8, (i < 8), (i == 8));
            end
            if (i == 8) begin
                checks++;
                if (sum8 !== 8'h8D || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_result: sum=%h cout=%b ovf=%b, want 8d 0 1", sum8, cout8, ovf8);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        int pulses;
        first_done = 0; second_done = 0; pulses = 0;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i == 9) begin
                a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1;
            end
            if (i == 10) start8 = 1'b0;
            @(posedge clk);
            #1;
            if (done8 === 1'b1) begin
                pulses++;
                if (first_done == 0) first_done = i;
                else if (second_done == 0) second_done = i;
            end
            if (i == 8) begin
                checks++;
                if (sum8 !== 8'h8D || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first_result: sum=%h cout=%b ovf=%b, want 8d 0 1", sum8, cout8, ovf8);
                end
            end
            if (i == 9) begin
                checks++;
                if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_restart: busy=%b done=%b, want 1 0", busy8, done8);
                end
            end
            if (i == 13) begin
                checks++;
                if (sum8 !== 8'h8D || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_held_result: sum=%h cout=%b ovf=%b, want 8d 0 1", sum8, cout8, ovf8);
                end
            end
            if (i == 17) begin
                checks++;
                if (sum8 !== 8'h7F || cout8 !== 1'b1 || ovf8 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_second_result: sum=%h cout=%b ovf=%b, want 7f 1 1", sum8, cout8, ovf8);
                end
            end
        end
        checks++;
        if (first_done !== 8 || second_done !== 17 || pulses !== 2) begin
            errors++;
            $display("FAIL b2b_timing: first=%0d second=%0d pulses=%0d, want 8 17 2",
                     first_done, second_done, pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) rst_n = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) begin
            errors++;
            $display("FAIL midrun_idle: busy=%b done=%b sum=%h, want 0 0 00", busy8, done8, sum8);
        end
        op8(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_w4_exhaustive();
        int lat_a, lat_b;
        int sa, sb, sr, tot;
        logic [5:0] got_a, got_b, exp_v;
        logic e_cout, e_ovf;
        logic [3:0] e_sum;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        @(negedge clk);
                        a4 = x[3:0]; b4 = y[3:0]; sub4 = s[0]; cin4 = c[0]; start4 = 1'b1;
                        @(posedge clk);
                        #1;
                        start4 = 1'b0;
                        lat_a = 0; lat_b = 0; got_a = '0; got_b = '0;
                        for (int i = 1; i <= 3; i++) begin
                            @(posedge clk);
                            #1;
                            if (doneA === 1'b1 && lat_a == 0) begin
                                lat_a = i; got_a = {coutA, ovfA, sumA};
                            end
                            if (doneB === 1'b1 && lat_b == 0) begin
                                lat_b = i; got_b = {coutB, ovfB, sumB};
                            end
                        end
                        // Unsigned view gives sum and carry; signed view gives overflow.
                        if (s == 1) tot = x + ((~y) & 15) + 1;
                        else        tot = x + y + c;
                        e_sum  = tot[3:0];
                        e_cout = tot[4];
                        sa = (x >= 8) ? x - 16 : x;
                        sb = (y >= 8) ? y - 16 : y;
                        sr = (s == 1) ? sa - sb : sa + sb + c;
                        e_ovf = (sr > 7) || (sr < -8);
                        exp_v = {e_cout, e_ovf, e_sum};
                        checks++;
                        if (lat_a !== 2 || got_a !== exp_v) begin
                            errors++;
                            $display("FAIL w4b2 a=%h b=%h sub=%0d cin=%0d: lat=%0d {cout,ovf,sum}=%h, want lat=2 %h",
                                     x, y, s, c, lat_a, got_a, exp_v);
                        end
                        checks++;
                        if (lat_b !== 1 || got_b !== exp_v) begin
                            errors++;
                            $display("FAIL w4b4 a=%h b=%h sub=%0d cin=%0d: lat=%0d {cout,ovf,sum}=%h, want lat=1 %h",
                                     x, y, s, c, lat_b, got_b, exp_v);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_add_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_w4_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
